// File: rtl/ps2_key_receiver_pkg.sv
// Shared PS/2 receiver definitions: scan-code prefixes, frame FSM encoding
// and the odd-parity helper used by the frame checker.
package ps2_key_receiver_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for received key codes; reads zero when empty and
// flags (sticky) any push dropped because it was full.
module key_fifo
    import ps2_key_receiver_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             overflow_q;
    logic             empty_s;
    logic             full_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty_s   = (count_q == '0);
    assign full_s    = (count_q == FULL_CNT);
    assign do_pop_s  = pop_i & ~empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push_s = push_i & (~full_s | do_pop_s);

    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_i & full_s & ~do_pop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o     = empty_s ? '0 : mem_q[rd_ptr_q];
    assign valid_o    = ~empty_s;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, decodes
// frames and E0/F0 prefixes, and queues make codes for the consumer.
module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       iPop,
    output logic [7:0] oKey,
    output logic       oKeyExt,
    output logic       oKeyValid,
    output logic       oFrameErr,
    output logic       oOverflow
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [1:0]    raw_s;
    logic [1:0]    filt_q;
    logic [FW-1:0] filt_cnt_q [2];
    logic          clk_prev_q;
    logic          strobe_s;
    logic          data_bit_s;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_ok_q;
    logic [TW-1:0] tmo_q;
    logic          frame_err_q;
    logic          ext_q;
    logic          brk_q;
    logic          push_q;
    logic [8:0]    push_data_q;
    logic [8:0]    head_s;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
        end
    end

    // Index 0 is the PS/2 clock, index 1 the PS/2 data line.
    assign raw_s = {data_sync_q[1], clk_sync_q[1]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                filt_cnt_q[i] <= '0;
            end
        end else begin
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (raw_s[i] == filt_q[i]) begin
                    filt_cnt_q[i] <= '0;
                end else if (filt_cnt_q[i] == FILT_LAST) begin
                    filt_q[i]     <= raw_s[i];
                    filt_cnt_q[i] <= '0;
                end else begin
                    filt_cnt_q[i] <= filt_cnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign strobe_s   = clk_prev_q & ~filt_q[0];
    assign data_bit_s = filt_q[1];

    // Prefix decoding happens on the stop strobe so the FIFO write lands one cycle later.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_ok_q <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 9'h000;
        end else begin
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            if ((state_q != ST_IDLE) && !strobe_s) begin
                if (tmo_q == TMO_LAST) begin
                    state_q     <= ST_IDLE;
                    bit_cnt_q   <= 3'd0;
                    shift_q     <= 8'h00;
                    tmo_q       <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end

            if (strobe_s) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_bit_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= {data_bit_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        parity_ok_q <= odd_parity_ok(shift_q, data_bit_s);
                        state_q     <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= 3'd0;
                        if (data_bit_s && parity_ok_q) begin
                            if (shift_q == PS2_PREFIX_EXT) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == PS2_PREFIX_BREAK) begin
                                brk_q <= 1'b1;
                            end else begin
                                if (!brk_q) begin
                                    push_q      <= 1'b1;
                                    push_data_q <= {ext_q, shift_q};
                                end
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    key_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .push_i     (push_q),
        .data_i     (push_data_q),
        .pop_i      (iPop),
        .data_o     (head_s),
        .valid_o    (oKeyValid),
        .overflow_o (oOverflow)
    );

    assign oKey      = head_s[7:0];
    assign oKeyExt   = head_s[8];
    assign oFrameErr = frame_err_q;

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, which is the number of consecutive equal samples needed to accept a PS/2 line level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, which is the maximum number of Clock cycles allowed between falling edges inside a frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, which is the number of key-code entries (power of two).
REQ-004 SHALL have port Clock, input, 1 bit: single system clock, all logic on posedge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port PS2_CLK, input, 1 bit: raw keyboard clock, asynchronous to Clock.
REQ-007 SHALL have port PS2_DATA, input, 1 bit: raw keyboard data, asynchronous to Clock.
REQ-008 SHALL have port iPop, input, 1 bit: consumer (TEC instruction) removes the head entry this cycle.
REQ-009 SHALL have port oKey, output, 8 bits: make code at the FIFO head; 8'h00 when empty.
REQ-010 SHALL have port oKeyExt, output, 1 bit: the head code was preceded by the 8'hE0 prefix.
REQ-011 SHALL have port oKeyValid, output, 1 bit: the FIFO is non-empty.
REQ-012 SHALL have port oFrameErr, output, 1 bit: one-cycle pulse on a parity, start, stop or timeout error.
REQ-013 SHALL have port oOverflow, output, 1 bit: sticky flag, set when a code was dropped because the FIFO was full.

Function
REQ-014 SHALL pass PS2_CLK and PS2_DATA through a 2-FF synchronizer, then a FILTER_LEN-sample glitch filter; the filtered level changes only after FILTER_LEN identical samples.
REQ-015 SHALL act on a frame event only at a filtered PS2_CLK 1->0 transition, detected as a one-cycle strobe.
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY, STOP, with a bit counter of 0..7.
REQ-017 IDLE: on a strobe with data=0, SHALL go to DATA with the counter at 0; on a strobe with data=1, SHALL stay in IDLE and pulse oFrameErr.
REQ-018 DATA: SHALL shift data LSB-first on each strobe; after the 8th bit it SHALL go to PARITY.
REQ-019 PARITY: SHALL require odd parity over the 8 data bits plus the parity bit; SHALL latch the result and go to STOP.
REQ-020 STOP: on a strobe, it SHALL accept the byte if data=1 and parity is good, otherwise pulse oFrameErr; either way it SHALL return to IDLE.
REQ-021 In any non-IDLE state, if no strobe arrives for TIMEOUT_CYCLES cycles, the FSM SHALL return to IDLE, discard the partial byte and pulse oFrameErr.
REQ-022 Prefix decoding of accepted bytes:
- 8'hE0 SHALL set the ext flag.
- 8'hF0 SHALL set the break flag.
- Any other byte with break=0 SHALL be pushed as {ext, byte}.
- Any other byte with break=1 SHALL be discarded.
- Both flags SHALL clear after any non-prefix byte.
REQ-023 A pushed entry SHALL appear on oKey/oKeyValid exactly 2 Clock cycles after the stop-bit strobe: cycle 1 decode, cycle 2 FIFO write visible.
REQ-024 FIFO ordering and empty behaviour:
- The FIFO SHALL be first-in first-out.
- iPop while empty SHALL be ignored.
- oKey and oKeyExt SHALL read 0 when empty.
REQ-025 Push while full without iPop SHALL drop the new entry and set oOverflow; stored entries SHALL be unchanged.
REQ-026 Push and iPop in the same cycle while full SHALL perform both; occupancy is unchanged and no overflow is flagged.
REQ-027 Push and iPop in the same cycle while empty SHALL leave the new entry stored; the pop is ignored.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with log2(FIFO_DEPTH)+1 bits.
REQ-029 oOverflow SHALL clear only on Reset.

Reset
REQ-030 Reset SHALL asynchronously force all of the following:
- FSM to IDLE.
- Counters, shift register, ext/break flags and the timeout counter to 0.
- FIFO empty.
- oKey=8'h00, oKeyExt=0, oKeyValid=0, oFrameErr=0, oOverflow=0.
- Filter outputs to 1 (PS/2 idle level).
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release, the next byte SHALL be received only once a valid start bit appears.

Structure
REQ-032 Constants PS2_PREFIX_EXT (8'hE0), PS2_PREFIX_BREAK (8'hF0) and the FSM state encodings SHALL reside in the shared definitions header used by the ALU opcodes.
REQ-033 The FIFO SHALL be a separate sub-module key_fifo (parameterized width 9, depth FIFO_DEPTH); synchronizer, filter, FSM and prefix decoder SHALL stay in ps2_key_receiver.

Verification
REQ-034 Scenario: send frame 8'h1C (parity 0, stop 1) -> oKeyValid=1 two cycles after the stop strobe, oKey=8'h1C, oKeyExt=0; iPop -> oKeyValid=0, oKey=8'h00.
REQ-035 Scenario: send E0,75 then E0,F0,75 -> exactly one entry, {ext=1, 8'h75}; the break sequence enqueues nothing.
REQ-036 Scenario: send 8'h1C with a bad parity bit -> one oFrameErr pulse, nothing enqueued; the next good frame 8'h32 is enqueued normally.
REQ-037 Scenario: stop PS2_CLK after 4 data bits for more than TIMEOUT_CYCLES -> oFrameErr pulse, FSM in IDLE; the following full frame 8'h1B is received correctly.
REQ-038 Scenario: enqueue 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C with no pops -> oOverflow=1 and oKey=8'h15; the pop sequence yields 15, 1D, 24, 2D, then empty; a 4-cycle PS2_CLK glitch produces no bit event.
REQ-039 Scenario: assert Reset in the middle of DATA -> all outputs return to their reset values immediately; after release, frame 8'h1C is received correctly.
